enc8x3_stream: RTL and testbench
================================

# enc8x3_stream

Registered 8-to-3 priority encoder with valid/ready handshakes on both sides, the inverse of the `dec3x8` decoder. It turns one-hot (or arbitrary) 8-bit request words into a 3-bit index. It flags words that are not strictly one-hot and keeps a saturating count of them. It sits downstream of `dec3x8`-driven logic, and the pair closes a decode/encode loop so round-trip checks run in simulation.

## Interface
- `PRIORITY_HIGH`, default 1: 1 = highest set bit index wins; 0 = lowest set bit index wins.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `A` input 8: request word.
- `a_valid` input 1: `A` is valid this cycle.
- `a_ready` output 1: block accepts `A` this cycle.
- `Y` output 3: encoded index of winning bit.
- `y_zero` output 1: accepted word had no bit set (`Y` = 0).
- `y_multi` output 1: accepted word had 2 or more bits set.
- `y_valid` output 1: `Y`/`y_zero`/`y_multi` valid.
- `y_ready` input 1: consumer takes output this cycle.
- `err_count` output 8: saturating count of accepted words with `y_zero` or `y_multi`.

## Operation
- Two-stage pipeline:
  - S1 is the capture register: `s1_valid`, `s1_A`.
  - S2 is the output register: `y_valid`, `Y`, `y_zero`, `y_multi`.
- Accept: `a_valid && a_ready` at an edge loads `A` into S1 and sets `s1_valid`.
- `a_ready` = `!rst && (!s1_valid || !y_valid || y_ready)`. It is combinational from registered state and `y_ready`; there is no path from `a_valid` to `a_ready`.
- S1 to S2 advance when `s1_valid && (!y_valid || y_ready)`.
- Encoding is done in the advance cycle from `s1_A`:
  - `Y` = index of the highest set bit (`PRIORITY_HIGH`=1) or the lowest set bit (`PRIORITY_HIGH`=0).
  - `y_zero` = (`s1_A` == 0), with `Y` = 0.
  - `y_multi` = popcount(`s1_A`) ≥ 2.
- S1 clears when it advances and no new word is accepted in the same edge. Simultaneous advance plus accept: S1 takes the new word and `s1_valid` stays 1.
- S2 clears (`y_valid` = 0) when `y_ready` is high and S1 has nothing to advance.
- While `y_valid && !y_ready`:
  - `Y`, `y_zero` and `y_multi` hold stable.
  - S1 may still fill once, after which `a_ready` = 0.
  - No data is dropped or duplicated.
- `err_count` increments by 1 at each S1 to S2 advance whose result has `y_zero || y_multi`. It saturates at 255 and does not wrap.
- Reset while words are in flight discards all in-flight data without emitting it.

## Timing
- Reset values: `y_valid`=0, `Y`=0, `y_zero`=0, `y_multi`=0, `err_count`=0, `s1_valid`=0; `a_ready`=0 while `rst`=1.
- First cycle after reset deasserts: `a_ready`=1.
- Latency: word accepted at edge k gives `y_valid`=1 with its result after edge k+1 if S2 is free or draining (`y_ready` high); otherwise at the edge after S2 frees.
- Throughput: 1 word/cycle sustained when `y_ready` is held at 1.
- Backpressure capacity: 2 words (S1 + S2). After both fill, `a_ready`=0 until `y_ready` is asserted.
- `err_count` update is visible the same cycle `y_valid` rises for the offending word.

## Test plan
- Round trip: drive `dec3x8` with A=0..7, feed its Y into `A`, keep `y_ready`=1.
  - Required: `Y` sequence 0,1,...,7 on consecutive cycles, first `y_valid` 2 cycles after first accept.
  - Required: `y_zero`=`y_multi`=0 throughout; `err_count`=0.
- Priority: `A`=8'b1010_0100.
  - `PRIORITY_HIGH`=1 gives `Y`=7, `y_multi`=1.
  - `PRIORITY_HIGH`=0 gives `Y`=2, `y_multi`=1.
  - `A`=8'h00 gives `Y`=0, `y_zero`=1.
  - `err_count` ends at 2 for each build.
- Backpressure: stream 8'h01,8'h02,8'h04 with `y_ready`=0.
  - Required: `a_ready` drops after 2 accepts; `Y`=0 holds stable.
  - Then raise `y_ready`: outputs 0,1,2 in order, no loss or duplication.
- Saturation: 300 accepted words of 8'hFF.
  - Required: `err_count` reaches 255 and stays at 255; each `Y`=7.
- Reset mid-stream: with S1 and S2 both full, assert `rst` for 1 cycle.
  - Required: next cycle `y_valid`=0, `err_count`=0, `a_ready`=0 during reset and 1 after.
  - Required: the subsequent word 8'h10 yields `Y`=4 only; no stale output appears.

Source files
------------

// File: rtl/enc8x3_stream.sv
// enc8x3_stream: registered 8-to-3 priority encoder with valid/ready on both
// sides. Two-stage pipeline: S1 captures the raw request word, S2 holds the
// encoded index plus zero/multi flags. Words that are not strictly one-hot
// bump a saturating error counter when they move into S2.
module enc8x3_stream #(
    parameter int unsigned PRIORITY_HIGH = 1  // 1: highest set bit wins, 0: lowest
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic       a_valid,
    output logic       a_ready,
    output logic [2:0] Y,
    output logic       y_zero,
    output logic       y_multi,
    output logic       y_valid,
    input  logic       y_ready,
    output logic [7:0] err_count
);

    // Stage 1: capture register
    logic       s1_valid_q, s1_valid_d;
    logic [7:0] s1_a_q,     s1_a_d;

    // Stage 2: output register
    logic       y_valid_q,  y_valid_d;
    logic [2:0] y_q,        y_d;
    logic       y_zero_q,   y_zero_d;
    logic       y_multi_q,  y_multi_d;

    // Saturating count of non-one-hot words
    logic [7:0] err_q,      err_d;

    // Handshake qualifiers
    logic       accept;
    logic       advance;

    // Encoder results computed from the S1 word
    logic [2:0] enc_idx;
    logic [3:0] enc_pop;
    logic       enc_zero;
    logic       enc_multi;

    // Ready depends only on registered state and the downstream ready, never
    // on a_valid, so no combinational loop can form through the upstream.
    assign a_ready = !rst && (!s1_valid_q || !y_valid_q || y_ready);
    assign accept  = a_valid && a_ready;
    assign advance = s1_valid_q && (!y_valid_q || y_ready);

    // Priority encode and popcount of the S1 word. The scan order makes the
    // last set bit visited the winner, so direction selects the priority.
    always_comb begin
        enc_idx = 3'd0;
        enc_pop = 4'd0;
        if (PRIORITY_HIGH != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (s1_a_q[i]) enc_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (s1_a_q[i]) enc_idx = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            enc_pop = enc_pop + {3'd0, s1_a_q[i]};
        end
        enc_zero  = (enc_pop == 4'd0);
        enc_multi = (enc_pop >= 4'd2);
    end

    // Next-state for both pipeline stages and the error counter
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        y_valid_d  = y_valid_q;
        y_d        = y_q;
        y_zero_d   = y_zero_q;
        y_multi_d  = y_multi_q;
        err_d      = err_q;

        // S2 drains when the consumer takes it; a refill below overrides.
        if (y_ready) y_valid_d = 1'b0;

        if (advance) begin
            y_valid_d  = 1'b1;
            y_d        = enc_idx;
            y_zero_d   = enc_zero;
            y_multi_d  = enc_multi;
            s1_valid_d = 1'b0;
            if ((enc_zero || enc_multi) && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end

        // A new word lands in S1 even when S1 advanced on the same edge.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = A;
        end
    end

    // State registers with synchronous reset; reset discards in-flight words
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= 8'd0;
            y_valid_q  <= 1'b0;
            y_q        <= 3'd0;
            y_zero_q   <= 1'b0;
            y_multi_q  <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            y_valid_q  <= y_valid_d;
            y_q        <= y_d;
            y_zero_q   <= y_zero_d;
            y_multi_q  <= y_multi_d;
            err_q      <= err_d;
        end
    end

    assign Y         = y_q;
    assign y_zero    = y_zero_q;
    assign y_multi   = y_multi_q;
    assign y_valid   = y_valid_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_enc8x3_stream.sv
// Self-checking bench for enc8x3_stream. Two instances (high and low
// priority) share all inputs; a transaction-level model (a FIFO of accepted
// words with capacity 2, front entry visible once it has reached the output)
// predicts every output each cycle.
module tb_enc8x3_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic       a_valid;
    logic       y_ready;

    logic       a_ready_h, y_zero_h, y_multi_h, y_valid_h;
    logic [2:0] Y_h;
    logic [7:0] err_h;
    logic       a_ready_l, y_zero_l, y_multi_l, y_valid_l;
    logic [2:0] Y_l;
    logic [7:0] err_l;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    logic [7:0] q[$];
    bit         out_present = 1'b0;
    int         m_err = 0;

    always #5 clk = ~clk;

    enc8x3_stream #(.PRIORITY_HIGH(1)) u_hi (
        .clk(clk), .rst(rst), .A(A), .a_valid(a_valid), .a_ready(a_ready_h),
        .Y(Y_h), .y_zero(y_zero_h), .y_multi(y_multi_h), .y_valid(y_valid_h),
        .y_ready(y_ready), .err_count(err_h)
    );

    enc8x3_stream #(.PRIORITY_HIGH(0)) u_lo (
        .clk(clk), .rst(rst), .A(A), .a_valid(a_valid), .a_ready(a_ready_l),
        .Y(Y_l), .y_zero(y_zero_l), .y_multi(y_multi_l), .y_valid(y_valid_l),
        .y_ready(y_ready), .err_count(err_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference encoding from arithmetic on the word value
    function automatic logic [2:0] ref_idx(input logic [7:0] w, input bit high);
        int x;
        x = int'(w);
        if (x == 0) return 3'd0;
        if (high) return 3'($clog2(x + 1) - 1);
        return 3'($clog2(x & -x));
    endfunction

    function automatic logic [7:0] dec3x8(input int i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    // One clock: drive, check ready mid-cycle, advance model, check outputs.
    task automatic cycle(input bit r, input bit av, input logic [7:0] a, input bit yr);
        bit exp_rdy;
        bit acc;
        logic [7:0] w;
        rst = r; a_valid = av; A = a; y_ready = yr;
        @(negedge clk);
        exp_rdy = !r && (q.size() < 2 || yr);
        chk("a_ready_hi", 32'(a_ready_h), 32'(exp_rdy));
        chk("a_ready_lo", 32'(a_ready_l), 32'(exp_rdy));
        @(posedge clk);
        acc = av && exp_rdy;
        if (r) begin
            q.delete();
            out_present = 1'b0;
            m_err = 0;
        end else begin
            if (out_present && yr) begin
                void'(q.pop_front());
                out_present = 1'b0;
            end
            if (!out_present && q.size() > 0) begin
                out_present = 1'b1;
                w = q[0];
                if ((w == 8'd0 || $countones(w) >= 2) && m_err < 255) m_err++;
            end
            if (acc) q.push_back(a);
        end
        #1;
        chk("y_valid_hi", 32'(y_valid_h), 32'(out_present));
        chk("y_valid_lo", 32'(y_valid_l), 32'(out_present));
        chk("err_hi", 32'(err_h), 32'(m_err));
        chk("err_lo", 32'(err_l), 32'(m_err));
        if (out_present) begin
            w = q[0];
            chk("Y_hi", 32'(Y_h), 32'(ref_idx(w, 1'b1)));
            chk("Y_lo", 32'(Y_l), 32'(ref_idx(w, 1'b0)));
            chk("y_zero", 32'(y_zero_h), 32'(w == 8'd0));
            chk("y_multi", 32'(y_multi_h), 32'($countones(w) >= 2));
            chk("y_zero_lo", 32'(y_zero_l), 32'(w == 8'd0));
            chk("y_multi_lo", 32'(y_multi_l), 32'($countones(w) >= 2));
        end else if (r) begin
            chk("rst_Y", 32'({Y_h, Y_l}), 32'(0));
            chk("rst_flags", 32'({y_zero_h, y_multi_h, y_zero_l, y_multi_l}), 32'(0));
        end
    endtask

    initial begin
        rst = 1'b1; A = 8'd0; a_valid = 1'b0; y_ready = 1'b0;

        // Reset state
        cycle(1, 0, 8'd0, 0);
        cycle(1, 1, 8'h01, 1);

        // Round trip through a decoder: indices 0..7 back-to-back
        for (int i = 0; i < 8; i++) cycle(0, 1, dec3x8(i), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 1);
        chk("rt_err", 32'(err_h), 32'(0));

        // Priority and zero word: two error events
        cycle(1, 0, 8'd0, 1);
        cycle(0, 1, 8'b1010_0100, 1);
        cycle(0, 1, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 1);
        chk("prio_err_hi", 32'(err_h), 32'(2));
        chk("prio_err_lo", 32'(err_l), 32'(2));

        // Backpressure: third word must wait until the consumer is ready
        cycle(1, 0, 8'd0, 0);
        cycle(0, 1, 8'h01, 0);
        cycle(0, 1, 8'h02, 0);
        cycle(0, 1, 8'h04, 0);
        cycle(0, 1, 8'h04, 0);
        chk("bp_stall", 32'(a_ready_h), 32'(0));
        cycle(0, 1, 8'h04, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'd0, 1);

        // Saturation of the error counter
        cycle(1, 0, 8'd0, 1);
        for (int i = 0; i < 300; i++) cycle(0, 1, 8'hFF, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 1);
        chk("sat_err_hi", 32'(err_h), 32'(255));
        chk("sat_err_lo", 32'(err_l), 32'(255));

        // Reset with both stages full, then one clean word
        cycle(0, 1, 8'h03, 0);
        cycle(0, 1, 8'h81, 0);
        cycle(1, 1, 8'h40, 0);
        cycle(0, 1, 8'h10, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a;
            if ($urandom_range(0, 2) == 0) a = 8'($urandom);
            else a = dec3x8(int'($urandom_range(0, 7)));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a,
                  $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
